nut_rom_fetch_seq: RTL

// - Word-cycle scheduler for the paged instruction ROM on the serial Nut bus.
// - Tracks the 56-bit-time word cycle and deserialises the fetch address from ia.
// - On a page hit, issues one read to the ROM array, then shifts the 10-bit word out on is.
// - Snoops ENBANK opcodes and drives the bank select d_page.

---
 rtl/nut_rom_fetch_seq.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/nut_rom_fetch_seq.sv
// -----------------------------------------------------------------------------
// nut_rom_fetch_seq
// Word-cycle scheduler for a paged instruction ROM on the serial Nut bus.
// Tracks the 56 bit-time word cycle, deserialises the fetch address from ia,
// issues one read per page hit to the ROM array and shifts the 10-bit word
// back out on is during bit-times 45..54.
//
// Optional feature macro: ROM_BANK_SWITCH_EN
//   defined     : ENBANK opcodes seen on isa_in after a word this ROM drove
//                 select the bank used in rom_adr[13:12] and on d_page.
//   not defined : bank logic removed, bank fixed at 0.
//
// Ports
//   cph1      in   bus clock, one posedge per bit-time
//   pon_n     in   asynchronous active-low reset
//   sync      in   bus sync, high during bit-times 45..54
//   ia        in   serial address, LSB first, bit-times 16..31
//   isa_in    in   serial instruction bus as seen by all devices
//   is        out  serial instruction data driven by this ROM
//   is_oe     out  high while is is driven
//   rom_req   out  read request to the ROM array
//   rom_adr   out  {bank, addr[11:0]}, stable while rom_req is high
//   rom_ack   in   one-cycle strobe qualifying rom_data
//   rom_data  in   instruction word
//   d_page    out  current bank select
//   fetch_err out  sticky, set when rom_ack misses the deadline
//
// Timing note: every registered output is computed from cnt_d, the bit-time
// that begins at the next posedge, so an output "at T45" is valid for the
// whole of bit-time 45.
// -----------------------------------------------------------------------------
module nut_rom_fetch_seq #(
  parameter logic [3:0] PAGE     = 4'hF,
  parameter int         DEADLINE = 44
) (
  input  logic        cph1,
  input  logic        pon_n,
  input  logic        sync,
  input  logic        ia,
  input  logic        isa_in,
  output logic        is,
  output logic        is_oe,
  output logic        rom_req,
  output logic [13:0] rom_adr,
  input  logic        rom_ack,
  input  logic [9:0]  rom_data,
  output logic [1:0]  d_page,
  output logic        fetch_err
);

  localparam logic [5:0] DL_C        = 6'(DEADLINE);
  localparam logic [5:0] DL1_C       = 6'(DEADLINE + 1);
  localparam logic [5:0] T_ADR_FIRST = 6'd16;
  localparam logic [5:0] T_ADR_LAST  = 6'd31;
  localparam logic [5:0] T_REQ       = 6'd32;
  localparam logic [5:0] T_OUT_FIRST = 6'd45;
  localparam logic [5:0] T_OUT_NEXT  = 6'd46;
  localparam logic [5:0] T_OUT_LAST  = 6'd54;
  localparam logic [5:0] T_LAST      = 6'd55;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  state_t      state_d, state_q;
  logic [5:0]  cnt_d, cnt_q;
  logic        sync_dly_d, sync_dly_q;
  logic        locked_d, locked_q;
  logic [15:0] adr_sr_d, adr_sr_q;
  logic        rom_req_d, rom_req_q;
  logic [13:0] rom_adr_d, rom_adr_q;
  logic [9:0]  inst_d, inst_q;
  logic        is_d, is_q;
  logic        is_oe_d, is_oe_q;
  logic        fetch_err_d, fetch_err_q;
  logic        sync_rise_s;
  logic        resync_s;
  logic [3:0]  shift_idx_s;
  logic [1:0]  bank_s;

  // Bit counter, sync edge detect, lock flag and address deserialiser.
  always_comb begin
    sync_dly_d  = sync;
    sync_rise_s = sync & ~sync_dly_q;
    // A sync rise anywhere but T45 means we were out of step with the bus.
    resync_s    = sync_rise_s & (cnt_q != T_OUT_FIRST);
    locked_d    = locked_q | sync_rise_s;
    if (sync_rise_s) begin
      cnt_d = T_OUT_NEXT;
    end else if (cnt_q == T_LAST) begin
      cnt_d = 6'd0;
    end else begin
      cnt_d = cnt_q + 6'd1;
    end
    if ((cnt_q >= T_ADR_FIRST) && (cnt_q <= T_ADR_LAST)) begin
      adr_sr_d = {ia, adr_sr_q[15:1]};
    end else begin
      adr_sr_d = adr_sr_q;
    end
    shift_idx_s = 4'(cnt_d - T_OUT_FIRST);
  end

  // Fetch FSM next state and registered bus/ROM outputs.
  always_comb begin
    state_d     = state_q;
    rom_req_d   = rom_req_q;
    rom_adr_d   = rom_adr_q;
    inst_d      = inst_q;
    is_d        = 1'b0;
    is_oe_d     = 1'b0;
    fetch_err_d = fetch_err_q;
    if (resync_s) begin
      state_d   = ST_IDLE;
      rom_req_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // adr_sr_d already holds the bit sampled in T31.
          if (locked_q && (cnt_d == T_REQ) && (adr_sr_d[15:12] == PAGE)) begin
            state_d   = ST_REQ;
            rom_req_d = 1'b1;
            rom_adr_d = {bank_s, adr_sr_d[11:0]};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (rom_ack && (cnt_q <= DL_C)) begin
            inst_d    = rom_data;
            rom_req_d = 1'b0;
            // An ack in the last accepted bit-time goes straight to output.
            if (cnt_d == T_OUT_FIRST) begin
              state_d = ST_SHIFT;
              is_oe_d = 1'b1;
              is_d    = rom_data[0];
            end else begin
              state_d = ST_HOLD;
            end
          end else if (cnt_d == DL1_C) begin
            state_d     = ST_IDLE;
            rom_req_d   = 1'b0;
            fetch_err_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_HOLD: begin
          if (cnt_d == T_OUT_FIRST) begin
            state_d = ST_SHIFT;
            is_oe_d = 1'b1;
            is_d    = inst_q[0];
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_SHIFT: begin
          if (cnt_d == T_LAST) begin
            state_d = ST_IDLE;
          end else begin
            is_oe_d = 1'b1;
            is_d    = inst_q[shift_idx_s];
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rom_req_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      sync_dly_q  <= 1'b0;
      locked_q    <= 1'b0;
      adr_sr_q    <= 16'h0000;
      rom_req_q   <= 1'b0;
      rom_adr_q   <= 14'h0000;
      inst_q      <= 10'h000;
      is_q        <= 1'b0;
      is_oe_q     <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_dly_q  <= sync_dly_d;
      locked_q    <= locked_d;
      adr_sr_q    <= adr_sr_d;
      rom_req_q   <= rom_req_d;
      rom_adr_q   <= rom_adr_d;
      inst_q      <= inst_d;
      is_q        <= is_d;
      is_oe_q     <= is_oe_d;
      fetch_err_q <= fetch_err_d;
    end
  end

`ifdef ROM_BANK_SWITCH_EN
  logic [9:0] op_sr_d, op_sr_q;
  logic [1:0] bank_d, bank_q;

  // ENBANK snoop: capture the bus opcode and retarget the bank after a word we drove.
  always_comb begin
    if ((cnt_q >= T_OUT_FIRST) && (cnt_q <= T_OUT_LAST)) begin
      op_sr_d = {isa_in, op_sr_q[9:1]};
    end else begin
      op_sr_d = op_sr_q;
    end
    // SHIFT ending into T55 marks a completed hit; op_sr_d includes the T54 bit.
    if ((state_q == ST_SHIFT) && (cnt_d == T_LAST)) begin
      case (op_sr_d)
        10'h100: bank_d = 2'd0;
        10'h180: bank_d = 2'd1;
        10'h140: bank_d = 2'd2;
        10'h1C0: bank_d = 2'd3;
        default: bank_d = bank_q;
      endcase
    end else begin
      bank_d = bank_q;
    end
  end

  // Opcode shifter and bank register.
  always_ff @(posedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      op_sr_q <= 10'h000;
      bank_q  <= 2'd0;
    end else begin
      op_sr_q <= op_sr_d;
      bank_q  <= bank_d;
    end
  end

  assign bank_s = bank_q;
`else
  logic unused_isa_s;
  assign unused_isa_s = isa_in;
  assign bank_s       = 2'd0;
`endif

  assign is        = is_q;
  assign is_oe     = is_oe_q;
  assign rom_req   = rom_req_q;
  assign rom_adr   = rom_adr_q;
  assign d_page    = bank_s;
  assign fetch_err = fetch_err_q;

endmodule
